// File: rtl/serial_adder_logic_ops_if.sv
// ============================================================================
// Module      : serial_adder_logic_ops_if
// Description : Bit-serial operand/result bundle for serial_adder_logic_ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_logic_ops_if;
    logic a;
    logic b;
    logic en;
    logic sum;
    logic carry;
    logic last;
    logic cout;

    modport master (
        output a,
        output b,
        output en,
        input  sum,
        input  carry,
        input  last,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  en,
        output sum,
        output carry,
        output last,
        output cout
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder_logic_ops.sv
// ============================================================================
// Module      : serial_adder_logic_ops
// Description : LSB-first bit-serial adder built from &,|,^,~ only.
//               Define SERIAL_ADDER_WORD_EN to compile in WORD_W-bit framing
//               (bit counter, last/cout, carry clear at word boundary).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_logic_ops #(
    parameter int WORD_W = 16
) (
    input  wire                        clk,
    input  wire                        rst,
    serial_adder_logic_ops_if.slave    bus
);

    if ((WORD_W < 2) || (WORD_W > 64)) begin : g_word_w_check
        $error("serial_adder_logic_ops: WORD_W must be in 2..64");
    end

    logic carry_q;
    logic carry_d;
    logic w_gen;
    logic w_prop;
    logic w_cout;

    assign w_gen  = bus.a & bus.b;
    assign w_prop = bus.a ^ bus.b;
    assign w_cout = w_gen | (carry_q & w_prop);

    assign bus.sum   = w_prop ^ carry_q;
    assign bus.carry = carry_q;

`ifdef SERIAL_ADDER_WORD_EN
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] w_idx_inc;
    logic [IDX_W-1:0] w_inc_c;
    logic             w_last;

    // Counter increment as a ripple of half-adders: sum = x^c, carry = x&c.
    assign w_inc_c[0] = 1'b1;
    for (genvar i = 0; i < IDX_W; i++) begin : g_inc
        assign w_idx_inc[i] = idx_q[i] ^ w_inc_c[i];
        if (i < IDX_W - 1) begin : g_ripple
            assign w_inc_c[i+1] = idx_q[i] & w_inc_c[i];
        end
    end

    assign w_last   = ~|(idx_q ^ LAST_IDX);
    assign bus.last = w_last;
    assign bus.cout = w_cout;

    always_comb begin
        carry_d = carry_q;
        idx_d   = idx_q;
        if (bus.en) begin
            if (w_last) begin
                carry_d = 1'b0;
                idx_d   = '0;
            end else begin
                carry_d = w_cout;
                idx_d   = w_idx_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
`else
    assign bus.last = 1'b0;
    assign bus.cout = 1'b0;

    always_comb begin
        carry_d = carry_q;
        if (bus.en) begin
            carry_d = w_cout;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_logic_ops.sv
// ============================================================================
// Module      : tb_serial_adder_logic_ops
// Description : Scoreboard bench for serial_adder_logic_ops (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_logic_ops;

`ifdef SERIAL_ADDER_WORD_EN
    localparam int WORD_W = 4;
`else
    localparam int WORD_W = 16;
`endif

    typedef struct {
        logic  sum;
        logic  carry;
        logic  last;
        logic  cout;
        logic  chk_cout;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    serial_adder_logic_ops_if bus ();

    serial_adder_logic_ops #(
        .WORD_W (WORD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string nm, input string field, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s.%s: got %b expected %b at %0t", nm, field, got, want, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; pop and compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                compare(e.name, "sum",   bus.sum,   e.sum);
                compare(e.name, "carry", bus.carry, e.carry);
                compare(e.name, "last",  bus.last,  e.last);
                if (e.chk_cout) compare(e.name, "cout", bus.cout, e.cout);
            end
        end
    end

    task automatic step(input logic r, input logic a_i, input logic b_i, input logic e_i,
                        input logic s, input logic c, input logic l, input logic co,
                        input logic chk, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst    = r;
        bus.a  = a_i;
        bus.b  = b_i;
        bus.en = e_i;
        e.sum = s; e.carry = c; e.last = l; e.cout = co; e.chk_cout = chk; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic reset_cycle(input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    initial begin
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] vs;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.a    = 1'b0;
        bus.b    = 1'b0;
        bus.en   = 1'b0;

        reset_cycle("reset");
        reset_cycle("reset");

`ifdef SERIAL_ADDER_WORD_EN
        // Word 1: 1111 + 0001 -> 0000, carry into bits 1..3 is 1, cout on bit 3.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0), 1'b1, 1'b0, (i != 0), (i == 3), 1'b1, (i == 3), "frame_w1");
        end
        // Word 2: 0001 + 0000 -> 0001 starting from a cleared carry.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), 1'b0, 1'b1, (i == 0), 1'b0, (i == 3), 1'b0, (i == 3), "frame_w2");
        end
        // Same first word with idle cycles between bits; last tracks the index.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0), 1'b1, 1'b0, (i != 0), (i == 3), 1'b1, (i == 3), "gap_bit");
            step(1'b1, 1'b0, 1'b0, 1'b0, (i != 3), (i != 3), (i == 2), 1'b0, 1'b0, "gap_idle");
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), 1'b0, 1'b1, (i == 0), 1'b0, (i == 3), 1'b0, (i == 3), "gap_w2");
        end
`else
        // 0x4DB4 + 0x1D62 = 0x6B16; carry into bit i is sum^a^b at that bit.
        va = 16'h4DB4;
        vb = 16'h1D62;
        vs = 16'h6B16;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, va[i], vb[i], 1'b1, vs[i], vs[i] ^ va[i] ^ vb[i], 1'b0, 1'b0, 1'b1, "word16");
        end

        reset_cycle("reset2");
        // 1111 + 0001: all sums 0, carry 1 after every edge.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0), 1'b1, 1'b0, (i != 0), 1'b0, 1'b0, 1'b1, "chain");
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "chain_out");

        reset_cycle("reset3");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gate_gen");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "gate_hold");
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "gate_use");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gate_clr");

        // Carry set, then reset asserted between edges clears it asynchronously.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_set");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst2");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
